// File: rtl/fetch_sequencer.sv
// rtl/fetch_sequencer.sv - instruction fetch sequencer: PC, single-outstanding imem transaction, one-word IF buffer
// Redirects from EX take priority over everything and retire any in-flight response as stale.
module fetch_sequencer #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  input  logic        stall,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_gnt,
  input  logic        imem_rvalid,
  input  logic [31:0] imem_rdata,
  output logic        if_valid,
  output logic [31:0] if_pc,
  output logic [31:0] if_inst,
  input  logic        if_ready,
  output logic        flush
);

  typedef enum logic [1:0] {
    ST_REQ   = 2'd0,
    ST_WAIT  = 2'd1,
    ST_DRAIN = 2'd2
  } state_t;

  state_t      state;
  logic [29:0] pc_word;
  logic [29:0] req_word;
  logic        issue;
  logic        capture;
  logic        unused_redirect_lsb;

  // Word-granular PC: the +1 increment wraps 0xFFFF_FFFC back to 0 naturally.
  assign unused_redirect_lsb = ^redirect_pc[1:0];
  assign imem_addr = {pc_word, 2'b00};
  assign imem_req  = rst_n && (state == ST_REQ) && !stall && !(if_valid && !if_ready)
                     && !redirect_valid;
  assign issue     = imem_req && imem_gnt;
  assign capture   = (state == ST_WAIT) && imem_rvalid && !redirect_valid;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= ST_REQ;
      pc_word  <= RESET_PC[31:2];
      req_word <= '0;
      if_valid <= 1'b0;
      if_pc    <= '0;
      if_inst  <= '0;
      flush    <= 1'b0;
    end else begin
      flush <= redirect_valid;

      if (redirect_valid) begin
        pc_word <= redirect_pc[31:2];
      end else if (issue) begin
        pc_word  <= pc_word + 30'd1;
        req_word <= pc_word;
      end

      if (redirect_valid) begin
        if_valid <= 1'b0;
      end else if (capture) begin
        if_valid <= 1'b1;
        if_pc    <= {req_word, 2'b00};
        if_inst  <= imem_rdata;
      end else if (if_valid && if_ready) begin
        if_valid <= 1'b0;
      end

      case (state)
        ST_REQ: begin
          if (issue) state <= ST_WAIT;
        end
        ST_WAIT: begin
          if (imem_rvalid)         state <= ST_REQ;
          else if (redirect_valid) state <= ST_DRAIN;
        end
        ST_DRAIN: begin
          if (imem_rvalid) state <= ST_REQ;
        end
        default: state <= ST_REQ;
      endcase
    end
  end

endmodule

// File: tb/tb_fetch_sequencer.sv
// tb/tb_fetch_sequencer.sv - directed self-checking bench for fetch_sequencer
module tb_fetch_sequencer;

  logic        clk;
  logic        rst_n;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        stall;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_gnt;
  logic        imem_rvalid;
  logic [31:0] imem_rdata;
  logic        if_valid;
  logic [31:0] if_pc;
  logic [31:0] if_inst;
  logic        if_ready;
  logic        flush;

  int total = 0;
  int bad   = 0;

  fetch_sequencer #(.RESET_PC(32'h8000_0000)) dut (
    .clk(clk), .rst_n(rst_n),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .stall(stall),
    .imem_req(imem_req), .imem_addr(imem_addr), .imem_gnt(imem_gnt),
    .imem_rvalid(imem_rvalid), .imem_rdata(imem_rdata),
    .if_valid(if_valid), .if_pc(if_pc), .if_inst(if_inst), .if_ready(if_ready),
    .flush(flush)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [31:0] inst_of(input logic [31:0] addr);
    return addr ^ 32'h1357_9BDF;
  endfunction

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%h expected=%h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Two-cycle fetch: request granted, then response returned on the following cycle.
  task automatic fetch_one(input logic [31:0] addr);
    imem_gnt = 1'b1; imem_rvalid = 1'b0;
    #1;
    check("req_issue", {31'd0, imem_req}, 32'd1);
    check("req_addr", imem_addr, addr);
    tick();
    imem_gnt = 1'b0; imem_rvalid = 1'b1; imem_rdata = inst_of(addr);
    #1;
    check("req_wait_low", {31'd0, imem_req}, 32'd0);
    tick();
    imem_rvalid = 1'b0; imem_rdata = 32'h0;
  endtask

  task automatic check_buf(input logic [31:0] pc);
    #1;
    check("if_valid", {31'd0, if_valid}, 32'd1);
    check("if_pc", if_pc, pc);
    check("if_inst", if_inst, inst_of(pc));
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst_n = 1'b0; redirect_valid = 1'b0; redirect_pc = 32'h0; stall = 1'b0;
    imem_gnt = 1'b0; imem_rvalid = 1'b0; imem_rdata = 32'h0; if_ready = 1'b1;
    #12;
    check("rst_req", {31'd0, imem_req}, 32'd0);
    check("rst_if_valid", {31'd0, if_valid}, 32'd0);
    check("rst_if_pc", if_pc, 32'h0);
    check("rst_if_inst", if_inst, 32'h0);
    check("rst_flush", {31'd0, flush}, 32'd0);
    check("rst_addr", imem_addr, 32'h8000_0000);
    tick();
    rst_n = 1'b1;

    // sequential fetch
    fetch_one(32'h8000_0000); check_buf(32'h8000_0000);
    fetch_one(32'h8000_0004); check_buf(32'h8000_0004);
    fetch_one(32'h8000_0008); check_buf(32'h8000_0008);

    // redirect while waiting, stale response two cycles later
    imem_gnt = 1'b1;
    #1; check("t2_req", {31'd0, imem_req}, 32'd1);
    check("t2_addr", imem_addr, 32'h8000_000C);
    tick();
    imem_gnt = 1'b0; redirect_valid = 1'b1; redirect_pc = 32'h0000_0103;
    #1; check("t2_redir_req", {31'd0, imem_req}, 32'd0);
    tick();
    redirect_valid = 1'b0;
    #1; check("t2_flush", {31'd0, flush}, 32'd1);
    check("t2_drain_req", {31'd0, imem_req}, 32'd0);
    check("t2_if_valid", {31'd0, if_valid}, 32'd0);
    tick();
    imem_rvalid = 1'b1; imem_rdata = 32'hDEAD_BEEF;
    #1; check("t2_flush_off", {31'd0, flush}, 32'd0);
    check("t2_drain_req2", {31'd0, imem_req}, 32'd0);
    tick();
    imem_rvalid = 1'b0;
    #1; check("t2_discard", {31'd0, if_valid}, 32'd0);
    check("t2_stale_inst", {31'd0, if_inst == 32'hDEAD_BEEF}, 32'd0);
    fetch_one(32'h0000_0100); check_buf(32'h0000_0100);

    // decode backpressure
    if_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      #1;
      check("t3_req", {31'd0, imem_req}, 32'd0);
      check("t3_pc", if_pc, 32'h0000_0100);
      check("t3_inst", if_inst, inst_of(32'h0000_0100));
      tick();
    end
    if_ready = 1'b1;
    fetch_one(32'h0000_0104); check_buf(32'h0000_0104);

    // stall holds the PC, stray gnt without req ignored
    stall = 1'b1; imem_gnt = 1'b1;
    for (int i = 0; i < 4; i++) begin
      #1;
      check("t4_req", {31'd0, imem_req}, 32'd0);
      check("t4_addr", imem_addr, 32'h0000_0108);
      tick();
    end
    stall = 1'b0;
    fetch_one(32'h0000_0108); check_buf(32'h0000_0108);

    // redirect coincident with rvalid in WAIT
    imem_gnt = 1'b1;
    #1; check("t5_addr", imem_addr, 32'h0000_010C);
    tick();
    imem_gnt = 1'b0; redirect_valid = 1'b1; redirect_pc = 32'h0000_0200;
    imem_rvalid = 1'b1; imem_rdata = 32'hBADB_AD00;
    tick();
    redirect_valid = 1'b0; imem_rvalid = 1'b0;
    #1; check("t5_flush", {31'd0, flush}, 32'd1);
    check("t5_if_valid", {31'd0, if_valid}, 32'd0);
    check("t5_req_in_req", {31'd0, imem_req}, 32'd1);
    fetch_one(32'h0000_0200); check_buf(32'h0000_0200);

    // PC wrap, then reset mid-transaction
    redirect_valid = 1'b1; redirect_pc = 32'hFFFF_FFFC;
    #1; check("t6_redir_req", {31'd0, imem_req}, 32'd0);
    tick();
    redirect_valid = 1'b0;
    fetch_one(32'hFFFF_FFFC); check_buf(32'hFFFF_FFFC);
    imem_gnt = 1'b1;
    #1; check("t6_wrap_addr", imem_addr, 32'h0000_0000);
    tick();
    imem_gnt = 1'b0;
    rst_n = 1'b0;
    #1;
    check("t6_rst_req", {31'd0, imem_req}, 32'd0);
    check("t6_rst_valid", {31'd0, if_valid}, 32'd0);
    check("t6_rst_pc", if_pc, 32'h0);
    check("t6_rst_inst", if_inst, 32'h0);
    check("t6_rst_addr", imem_addr, 32'h8000_0000);
    tick();
    rst_n = 1'b1;
    imem_rvalid = 1'b1; imem_rdata = 32'h1234_5678;
    #1; check("t6_late_req", {31'd0, imem_req}, 32'd1);
    tick();
    imem_rvalid = 1'b0;
    #1; check("t6_late_ignored", {31'd0, if_valid}, 32'd0);
    fetch_one(32'h8000_0000); check_buf(32'h8000_0000);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
